// File: rtl/det_count_display.sv
// det_count_display: counts detection pulses as a two-digit BCD value (00-99),
// multiplexes the tens/units digits onto a single 7-segment output and shows
// a full-on "8." flash for a few cycles after every detection.
module det_count_display #(
    parameter int unsigned DWELL_CYCLES = 50000,
    parameter int unsigned FLASH_CYCLES = 8,
    parameter int unsigned TMR_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       det_i,
    input  logic       clr_i,
    output logic [7:0] seg_o,
    output logic [7:0] count_bcd_o,
    output logic       ovf_o
);

    typedef enum logic [1:0] {
        S_TENS  = 2'd0,
        S_UNITS = 2'd1,
        S_FLASH = 2'd2
    } state_t;

    localparam logic [TMR_W-1:0] DWELL_LAST = TMR_W'(DWELL_CYCLES - 1);
    localparam logic [TMR_W-1:0] FLASH_LAST = TMR_W'(FLASH_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nxt;

    logic [3:0]       tens;
    logic [3:0]       units;
    logic [3:0]       tens_nxt;
    logic [3:0]       units_nxt;
    logic             ovf;
    logic             ovf_nxt;

    logic [7:0]       seg_nxt;

    // BCD digit to segments a..g (bit 0 = a); non-BCD codes blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // State and dwell/flash timer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_TENS;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // Next state: clear beats detection, detection beats dwell/flash timing.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        if (ena) begin
            if (clr_i) begin
                state_nxt = S_TENS;
                timer_nxt = '0;
            end else if (det_i) begin
                state_nxt = S_FLASH;
                timer_nxt = '0;
            end else begin
                case (state)
                    S_TENS: begin
                        if (timer == DWELL_LAST) begin
                            state_nxt = S_UNITS;
                            timer_nxt = '0;
                        end else begin
                            timer_nxt = timer + TMR_ONE;
                        end
                    end
                    S_UNITS: begin
                        if (timer == DWELL_LAST) begin
                            state_nxt = S_TENS;
                            timer_nxt = '0;
                        end else begin
                            timer_nxt = timer + TMR_ONE;
                        end
                    end
                    S_FLASH: begin
                        if (timer == FLASH_LAST) begin
                            state_nxt = S_TENS;
                            timer_nxt = '0;
                        end else begin
                            timer_nxt = timer + TMR_ONE;
                        end
                    end
                    default: begin
                        state_nxt = S_TENS;
                        timer_nxt = '0;
                    end
                endcase
            end
        end
    end

    // Count and sticky overflow register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tens  <= '0;
            units <= '0;
            ovf   <= 1'b0;
        end else begin
            tens  <= tens_nxt;
            units <= units_nxt;
            ovf   <= ovf_nxt;
        end
    end

    // BCD increment with carry; 99 wraps to 00 and latches overflow.
    always_comb begin
        tens_nxt  = tens;
        units_nxt = units;
        ovf_nxt   = ovf;
        if (ena) begin
            if (clr_i) begin
                tens_nxt  = '0;
                units_nxt = '0;
                ovf_nxt   = 1'b0;
            end else if (det_i) begin
                if (units >= 4'd9) begin
                    units_nxt = '0;
                    if (tens >= 4'd9) begin
                        tens_nxt = '0;
                        ovf_nxt  = 1'b1;
                    end else begin
                        tens_nxt = tens + 4'd1;
                    end
                end else begin
                    units_nxt = units + 4'd1;
                end
            end
        end
    end

    // Segment pattern for the currently registered state and count.
    always_comb begin
        seg_nxt = '0;
        case (state)
            S_TENS:  seg_nxt = {1'b1, seg7(tens)};
            S_UNITS: seg_nxt = {1'b0, seg7(units)};
            S_FLASH: seg_nxt = '1;
            default: seg_nxt = '0;
        endcase
    end

    // Output register: seg_o trails the state/count by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_o <= '0;
        end else if (ena) begin
            seg_o <= seg_nxt;
        end
    end

    assign count_bcd_o = {tens, units};
    assign ovf_o       = ovf;

endmodule

// File: tb/tb_det_count_display.sv
// Scoreboard bench for det_count_display: the stimulus side advances a
// behavioural model (integer count, flash countdown, dwell age) and queues the
// expected outputs; a monitor on the falling edge pops and compares.
module tb_det_count_display;

    localparam int DWELL = 4;
    localparam int FLASH = 3;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       det_i;
    logic       clr_i;
    logic [7:0] seg_o;
    logic [7:0] count_bcd_o;
    logic       ovf_o;

    det_count_display #(
        .DWELL_CYCLES(DWELL),
        .FLASH_CYCLES(FLASH),
        .TMR_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ena(ena),
        .det_i(det_i),
        .clr_i(clr_i),
        .seg_o(seg_o),
        .count_bcd_o(count_bcd_o),
        .ovf_o(ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] cnt;
        logic       ovf;
        logic [7:0] seg;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Reference model state.
    int         m_cnt   = 0;
    bit         m_ovf   = 0;
    int         m_flash = 0;
    bit         m_tens  = 1;
    int         m_age   = 0;
    logic [7:0] m_seg   = 8'h00;
    logic [6:0] lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic logic [7:0] m_disp();
        if (m_flash > 0) return 8'hFF;
        if (m_tens) return {1'b1, lut[m_cnt / 10]};
        return {1'b0, lut[m_cnt % 10]};
    endfunction

    function automatic void model_edge(input bit r, input bit e, input bit d, input bit c);
        if (r) begin
            m_cnt = 0; m_ovf = 0; m_flash = 0; m_tens = 1; m_age = 0; m_seg = 8'h00;
        end else if (e) begin
            m_seg = m_disp();
            if (c) begin
                m_cnt = 0; m_ovf = 0; m_flash = 0; m_tens = 1; m_age = 0;
            end else if (d) begin
                if (m_cnt == 99) m_ovf = 1;
                m_cnt   = (m_cnt + 1) % 100;
                m_flash = FLASH;
                m_age   = 0;
            end else if (m_flash > 0) begin
                m_flash = m_flash - 1;
                if (m_flash == 0) begin
                    m_tens = 1;
                    m_age  = 0;
                end
            end else begin
                m_age = m_age + 1;
                if (m_age == DWELL) begin
                    m_age  = 0;
                    m_tens = !m_tens;
                end
            end
        end
    endfunction

    task automatic step(input bit r, input bit e, input bit d, input bit c);
        exp_t x;
        rst = r; ena = e; det_i = d; clr_i = c;
        @(posedge clk);
        #1;
        cycle = cycle + 1;
        model_edge(r, e, d, c);
        x.cyc = cycle;
        x.cnt = {4'(m_cnt / 10), 4'(m_cnt % 10)};
        x.ovf = m_ovf;
        x.seg = m_seg;
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0);
    endtask

    task automatic dets(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 1, 0);
    endtask

    // Monitor: every cycle is an output beat; compare away from the rising edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            checks = checks + 1;
            if (count_bcd_o !== x.cnt) begin
                errors = errors + 1;
                $display("FAIL count cyc=%0d got=%h exp=%h", x.cyc, count_bcd_o, x.cnt);
            end
            checks = checks + 1;
            if (ovf_o !== x.ovf) begin
                errors = errors + 1;
                $display("FAIL ovf cyc=%0d got=%b exp=%b", x.cyc, ovf_o, x.ovf);
            end
            checks = checks + 1;
            if (seg_o !== x.seg) begin
                errors = errors + 1;
                $display("FAIL seg cyc=%0d got=%h exp=%h", x.cyc, seg_o, x.seg);
            end
        end
    end

    initial begin
        rst = 1'b1; ena = 1'b1; det_i = 1'b0; clr_i = 1'b0;

        // Reset release and idle dwell alternation.
        step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
        idle(12);
        // Single detection and flash.
        dets(1);
        idle(12);
        // 100 back-to-back detections: 09->10 and 99->00 wrap.
        dets(100);
        idle(6);
        // Clear and detection together at count 42.
        dets(41);
        idle(2);
        step(0, 1, 1, 1);
        idle(6);
        // Freeze mid-flash with det_i pulsing.
        dets(1);
        idle(1);
        for (int i = 0; i < 10; i++) step(0, 0, 1'(i % 2), 0);
        idle(6);
        // Reset in UNITS with count 57 and overflow set.
        dets(56);
        dets(100);
        idle(3 + DWELL + 1);
        step(1, 1, 0, 0);
        idle(4);
        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 99) < 85),
                 ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 3));
        end
        idle(2);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/det_count_display.md
Name: det_count_display

Overview:
Downstream display stage for the sequence detector. Consumes the detector's one-cycle detection pulse and keeps a two-digit BCD count of detections (00-99). It drives the single 7-segment output, alternating between the tens and units digit. Each new detection is acknowledged with a short full-on "8." flash.

Parameters:
DWELL_CYCLES, 50000, clock cycles each digit stays on the display before the tens/units phase toggles (>=2)
FLASH_CYCLES, 8, clock cycles the "8." acknowledge pattern is held after a detection (>=1)
TMR_W, 16, width of the shared dwell/flash timer; must hold max(DWELL_CYCLES, FLASH_CYCLES)-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
ena  input  1  design enable; low freezes all state
det_i  input  1  detection pulse from the sequence detector, one cycle per detection
clr_i  input  1  synchronous clear of count, overflow and display phase
seg_o  output  8  segment drive: [0]=a [1]=b [2]=c [3]=d [4]=e [5]=f [6]=g [7]=dp, active high
count_bcd_o  output  8  current count, [7:4] tens BCD, [3:0] units BCD
ovf_o  output  1  sticky; set when the count wraps 99->00

Behaviour:
- Reset (rst=1 at a clk edge) has priority over everything. It sets count_bcd_o=8'h00, ovf_o=0, state=TENS, timer=0 and seg_o=8'h00 (blank).
- ena=0 with rst=0: count, ovf, state, timer and seg_o all hold; det_i and clr_i are ignored.
- Priority when ena=1: rst > clr_i > det_i > dwell/flash timing.
- clr_i=1: count=00, ovf=0, state=TENS, timer=0. A det_i in the same cycle is dropped.
- BCD increment on det_i=1:
  - units 9 -> 0 with carry into tens.
  - 99 -> 00 and ovf_o set to 1; ovf_o stays set until rst or clr_i.
  - Digits never hold values A-F.
- States: TENS, UNITS, FLASH.
  - TENS: displays the tens digit with dp=1. When timer reaches DWELL_CYCLES-1, go to UNITS and clear timer; otherwise timer+1.
  - UNITS: displays the units digit with dp=0. When timer reaches DWELL_CYCLES-1, go to TENS and clear timer; otherwise timer+1.
  - FLASH: displays 8'hFF. When timer reaches FLASH_CYCLES-1, go to TENS and clear timer; otherwise timer+1.
  - det_i=1 in any state (including FLASH): go to FLASH with timer=0. A detection during FLASH is still counted and restarts the flash.
- Digit encoding (bits [6:0]): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. Tens phase ORs in 8'h80.
- Latency:
  - count_bcd_o and state update at the edge that samples det_i/clr_i (N+1).
  - seg_o is registered from the new state and count one cycle later (N+2).
- Back-to-back det_i on consecutive cycles each increment; no pulse is lost.

Test Plan:
1. Reset release (DWELL_CYCLES=4, FLASH_CYCLES=3), idle -> seg_o 00 during reset, then BF (tens "0."), after 4 cycles 3F (units "0"), then BF again; count_bcd_o=00, ovf_o=0.
2. Single det_i pulse -> count_bcd_o=01 at N+1; seg_o=FF for 3 cycles from N+2, then BF, then after dwell 06.
3. 100 det_i pulses back to back -> count passes 09->10 and 99->00; ovf_o=1 from the wrap cycle onward; seg_o stays FF until 3 cycles after the last pulse.
4. det_i and clr_i high in the same cycle with count=42 -> count_bcd_o=00, ovf_o=0, state TENS (seg_o BF), no FLASH.
5. ena=0 for 10 cycles mid-FLASH, with det_i pulsing -> count, timer and seg_o frozen (FF); flash resumes its remaining cycles once ena=1.
6. rst asserted mid-UNITS with count=57 and ovf_o=1 -> next edge count=00, ovf_o=0, seg_o=00, then BF.
